// File: rtl/rv32_mc_ctrl.sv
// rv32_mc_ctrl: multi-cycle RV32I control FSM sequencing fetch, decode, execute, memory and write-back.
module rv32_mc_ctrl #(
  parameter int CNT_W     = 32,
  parameter bit STRICT_F7 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             alu_zf,
  output logic             PC_Write,
  output logic             PC0_Write,
  output logic             IR_Write,
  output logic             rs_Write,
  output logic             F_Write,
  output logic             rd_Write,
  output logic [3:0]       ALU_OP,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       wdata_sel,
  output logic [1:0]       pc_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EX_R, EX_I, WB_ALU, LUI, MEM_ADDR,
    MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL, JALR_EX, JALR_WB, AUIPC
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic r_ok, done;
  assign r_ok = !STRICT_F7 || funct7 == 7'h00 ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
  // Terminal states always return to FETCH, so leaving one retires an instruction.
  assign done = state_q inside {WB_ALU, LUI, WB_MEM, MEM_WR, BRANCH, JAL, JALR_WB};
  assign retired_d = done ? retired_q + 1'b1 : retired_q;
  assign state = state_q;
  assign retired = retired_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    PC_Write  = 1'b0;
    PC0_Write = 1'b0;
    IR_Write  = 1'b0;
    rs_Write  = 1'b0;
    F_Write   = 1'b0;
    rd_Write  = 1'b0;
    ALU_OP    = 4'b0000;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    wdata_sel = 2'b00;
    pc_sel    = 2'b00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        IR_Write  = 1'b1;
        PC_Write  = 1'b1;
        PC0_Write = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        rs_Write = 1'b1;
        case (opcode)
          7'b0110011: state_d = r_ok ? EX_R : FETCH;
          7'b0010011: state_d = EX_I;
          7'b0110111: state_d = LUI;
          7'b0000011, 7'b0100011: state_d = MEM_ADDR;
          7'b1100011: state_d = BRANCH;
          7'b1101111: state_d = JAL;
          7'b1100111: state_d = JALR_EX;
          7'b0010111: state_d = AUIPC;
          default:    state_d = FETCH;
        endcase
        illegal = state_d == FETCH;
      end
      EX_R: begin
        ALU_OP  = {funct7[5], funct3};
        F_Write = 1'b1;
        state_d = WB_ALU;
      end
      EX_I: begin
        alu_b_sel = 1'b1;
        F_Write   = 1'b1;
        ALU_OP    = {funct3 == 3'b101 ? funct7[5] : 1'b0, funct3};
        state_d   = WB_ALU;
      end
      AUIPC: begin
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b1;
        F_Write   = 1'b1;
        state_d   = WB_ALU;
      end
      WB_ALU: begin
        rd_Write = 1'b1;
        state_d  = FETCH;
      end
      LUI: begin
        rd_Write  = 1'b1;
        wdata_sel = 2'b01;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        alu_b_sel = 1'b1;
        F_Write   = 1'b1;
        state_d   = opcode == 7'b0000011 ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_rd  = 1'b1;
        state_d = WB_MEM;
      end
      WB_MEM: begin
        mem_rd    = 1'b1;
        rd_Write  = 1'b1;
        wdata_sel = 2'b11;
        state_d   = FETCH;
      end
      MEM_WR: begin
        mem_wr  = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALU_OP   = 4'b1000;
        pc_sel   = 2'b01;
        PC_Write = (funct3 == 3'b000 && alu_zf) || (funct3 == 3'b001 && !alu_zf);
        state_d  = FETCH;
      end
      JAL: begin
        rd_Write  = 1'b1;
        wdata_sel = 2'b10;
        PC_Write  = 1'b1;
        pc_sel    = 2'b01;
        state_d   = FETCH;
      end
      JALR_EX: begin
        alu_b_sel = 1'b1;
        F_Write   = 1'b1;
        state_d   = JALR_WB;
      end
      JALR_WB: begin
        rd_Write  = 1'b1;
        wdata_sel = 2'b10;
        PC_Write  = 1'b1;
        pc_sel    = 2'b10;
        state_d   = FETCH;
      end
    endcase
  end
endmodule
